// File: rtl/window_pkg.sv
// Shared band encoding and flag classifier for the window comparator monitor.
package window_pkg;

  typedef enum logic [1:0] {S_OK, S_HIGH, S_LOW} band_t;

  typedef struct packed {
    logic  legal;
    band_t band;
  } class_t;

  // Only the three one-hot patterns are legal; anything else reports legal = 0.
  function automatic class_t classify(input logic th, input logic ok, input logic tl);
    class_t c;
    c.legal = 1'b1;
    c.band  = S_OK;
    case ({th, ok, tl})
      3'b100:  c.band  = S_HIGH;
      3'b010:  c.band  = S_OK;
      3'b001:  c.band  = S_LOW;
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/window_monitor_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/window_monitor.sv
// Debounces the window comparator's one-hot flags into a clean band, with a
// sticky alarm, a saturating excursion count and an illegal-pattern fault flag.
module window_monitor
  import window_pkg::*;
#(
  parameter int PERSIST = 4,
  parameter int CW      = 8
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          Too_High,
  input  logic          OK,
  input  logic          Too_Low,
  input  logic          Clear,
  output logic          In_Range,
  output logic          Alarm_High,
  output logic          Alarm_Low,
  output logic          Latched_Alarm,
  output logic [CW-1:0] Excursions,
  output logic          Fault
);

  localparam int CNT_W = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);

  if (PERSIST < 1 || PERSIST > 15) begin : g_bad_persist
    $error("window_monitor: PERSIST must be in 1..15");
  end

  band_t             state, state_n;
  band_t             cand, cand_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0]  run_len;
  class_t            cls;
  logic              entry;
  logic              excursion;

  assign cls = classify(Too_High, OK, Too_Low);

  // A run continues only while samples match the held candidate; reaching
  // PERSIST commits the band and rearms the counter on the same edge.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    run_len = '0;
    if (cls.legal) begin
      if (cls.band == state) begin
        cnt_n = '0;
      end else begin
        if (cls.band == cand && cnt != '0) begin
          run_len = cnt + CNT_W'(1);
        end else begin
          cand_n  = cls.band;
          run_len = CNT_W'(1);
        end
        if (run_len == PERSIST_C) begin
          state_n = cls.band;
          cnt_n   = '0;
        end else begin
          cnt_n = run_len;
        end
      end
    end
  end

  assign entry     = (state_n != state) && (state_n != S_OK);
  assign excursion = entry && (state == S_OK);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= S_OK;
      cand  <= S_OK;
      cnt   <= '0;
      Fault <= 1'b0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      Fault <= ~cls.legal;
    end
  end

  // Clear is honoured only once the band is back to OK; a new entry wins.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Latched_Alarm <= 1'b0;
    end else if (entry) begin
      Latched_Alarm <= 1'b1;
    end else if (Clear && state == S_OK) begin
      Latched_Alarm <= 1'b0;
    end
  end

  sat_counter #(.W(CW)) u_excursions (
    .Clock  (Clock),
    .nReset (nReset),
    .inc    (excursion),
    .count  (Excursions)
  );

  assign In_Range   = (state == S_OK);
  assign Alarm_High = (state == S_HIGH);
  assign Alarm_Low  = (state == S_LOW);

endmodule

// File: tb/tb_window_monitor.sv
// Directed self-checking bench for window_monitor with PERSIST = 4, CW = 8.
module tb_window_monitor;

  logic       Clock;
  logic       nReset;
  logic       Too_High;
  logic       OK;
  logic       Too_Low;
  logic       Clear;
  logic       In_Range;
  logic       Alarm_High;
  logic       Alarm_Low;
  logic       Latched_Alarm;
  logic [7:0] Excursions;
  logic       Fault;

  int tests;
  int failed;
  int exp_exc;

  window_monitor #(.PERSIST(4), .CW(8)) dut (
    .Clock         (Clock),
    .nReset        (nReset),
    .Too_High      (Too_High),
    .OK            (OK),
    .Too_Low       (Too_Low),
    .Clear         (Clear),
    .In_Range      (In_Range),
    .Alarm_High    (Alarm_High),
    .Alarm_Low     (Alarm_Low),
    .Latched_Alarm (Latched_Alarm),
    .Excursions    (Excursions),
    .Fault         (Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Inputs change on the falling edge; outputs are observed 1 ns after the rising edge.
  task automatic drive(input logic th, input logic ok, input logic tl, input logic clr);
    @(negedge Clock);
    Too_High = th;
    OK       = ok;
    Too_Low  = tl;
    Clear    = clr;
    @(posedge Clock);
    #1;
  endtask

  task automatic back_to_ok_and_clear();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (Alarm_High !== 1'b1) begin
      failed++;
      $display("[TB] FAIL pre_reset_high: got %b want 1", Alarm_High);
    end
    #2;
    nReset = 1'b0;
    #1;
    tests++;
    if (In_Range !== 1'b1 || Alarm_High !== 1'b0 || Alarm_Low !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_band: got IR=%b AH=%b AL=%b want 1 0 0", In_Range, Alarm_High, Alarm_Low);
    end
    tests++;
    if (Latched_Alarm !== 1'b0 || Fault !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_flags: got LA=%b F=%b want 0 0", Latched_Alarm, Fault);
    end
    tests++;
    if (Excursions !== 8'd0 || dut.cnt !== 3'd0) begin
      failed++;
      $display("[TB] FAIL reset_counts: got exc=%0d cnt=%0d want 0 0", Excursions, dut.cnt);
    end
    @(negedge Clock);
    nReset = 1'b1;
    exp_exc = 0;
  endtask

  task automatic test_persistence();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tests++;
      if (Alarm_High !== 1'b0 || In_Range !== 1'b1) begin
        failed++;
        $display("[TB] FAIL persist_early_%0d: got AH=%b IR=%b want 0 1", i, Alarm_High, In_Range);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_exc++;
    tests++;
    if (Alarm_High !== 1'b1 || In_Range !== 1'b0 || Alarm_Low !== 1'b0) begin
      failed++;
      $display("[TB] FAIL persist_high: got AH=%b IR=%b AL=%b want 1 0 0", Alarm_High, In_Range, Alarm_Low);
    end
    tests++;
    if (Latched_Alarm !== 1'b1 || Excursions !== 8'(exp_exc)) begin
      failed++;
      $display("[TB] FAIL persist_latch: got LA=%b exc=%0d want 1 %0d", Latched_Alarm, Excursions, exp_exc);
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    tests++;
    if (Latched_Alarm !== 1'b1) begin
      failed++;
      $display("[TB] FAIL clear_ignored_in_high: got %b want 1", Latched_Alarm);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tests++;
      if (In_Range !== (i == 4)) begin
        failed++;
        $display("[TB] FAIL clear_return_%0d: got IR=%b want %b", i, In_Range, (i == 4));
      end
    end
    tests++;
    if (Latched_Alarm !== 1'b1 || Excursions !== 8'(exp_exc)) begin
      failed++;
      $display("[TB] FAIL clear_not_queued: got LA=%b exc=%0d want 1 %0d", Latched_Alarm, Excursions, exp_exc);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    tests++;
    if (Latched_Alarm !== 1'b0) begin
      failed++;
      $display("[TB] FAIL clear_in_ok: got %b want 0", Latched_Alarm);
    end
  endtask

  task automatic test_glitch();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (dut.cnt !== 3'd0) begin
      failed++;
      $display("[TB] FAIL glitch_restart: got cnt=%0d want 0", dut.cnt);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (Alarm_High !== 1'b0 || dut.cnt !== 3'd3) begin
      failed++;
      $display("[TB] FAIL glitch_hold: got AH=%b cnt=%0d want 0 3", Alarm_High, dut.cnt);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_exc++;
    tests++;
    if (Alarm_High !== 1'b1 || Excursions !== 8'(exp_exc)) begin
      failed++;
      $display("[TB] FAIL glitch_accept: got AH=%b exc=%0d want 1 %0d", Alarm_High, Excursions, exp_exc);
    end
    back_to_ok_and_clear();
  endtask

  task automatic test_fault();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (Fault !== 1'b0) begin
      failed++;
      $display("[TB] FAIL fault_idle: got %b want 0", Fault);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (Fault !== 1'b1 || dut.cnt !== 3'd2) begin
      failed++;
      $display("[TB] FAIL fault_set: got F=%b cnt=%0d want 1 2", Fault, dut.cnt);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (Fault !== 1'b0 || Alarm_High !== 1'b0) begin
      failed++;
      $display("[TB] FAIL fault_one_cycle: got F=%b AH=%b want 0 0", Fault, Alarm_High);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_exc++;
    tests++;
    if (Alarm_High !== 1'b1 || Excursions !== 8'(exp_exc)) begin
      failed++;
      $display("[TB] FAIL fault_paused_run: got AH=%b exc=%0d want 1 %0d", Alarm_High, Excursions, exp_exc);
    end
  endtask

  task automatic test_direct();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tests++;
      if (Alarm_High !== (i < 4) || Alarm_Low !== (i == 4)) begin
        failed++;
        $display("[TB] FAIL direct_%0d: got AH=%b AL=%b want %b %b", i, Alarm_High, Alarm_Low, (i < 4), (i == 4));
      end
    end
    tests++;
    if (Excursions !== 8'(exp_exc) || Latched_Alarm !== 1'b1) begin
      failed++;
      $display("[TB] FAIL direct_no_count: got exc=%0d LA=%b want %0d 1", Excursions, Latched_Alarm, exp_exc);
    end
    back_to_ok_and_clear();
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
      exp_exc = (exp_exc < 255) ? exp_exc + 1 : 255;
      tests++;
      if (Alarm_Low !== 1'b1 || Excursions !== 8'(exp_exc)) begin
        failed++;
        $display("[TB] FAIL sat_low_%0d: got AL=%b exc=%0d want 1 %0d", n, Alarm_Low, Excursions, exp_exc);
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
      tests++;
      if (Alarm_Low !== 1'b0 || In_Range !== 1'b1) begin
        failed++;
        $display("[TB] FAIL sat_ok_%0d: got AL=%b IR=%b want 0 1", n, Alarm_Low, In_Range);
      end
    end
    tests++;
    if (Excursions !== 8'd255) begin
      failed++;
      $display("[TB] FAIL sat_final: got %0d want 255", Excursions);
    end
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    exp_exc  = 0;
    nReset   = 1'b0;
    Too_High = 1'b0;
    OK       = 1'b1;
    Too_Low  = 1'b0;
    Clear    = 1'b0;
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    test_reset();
    test_persistence();
    test_clear();
    test_glitch();
    test_fault();
    test_direct();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
